// File: rtl/timer_pkg.sv
// Shared constants for the Timer0 controller: register map, clock-select codes
// and bit positions inside the control/status registers.
package timer_pkg;

  localparam logic [2:0] TCCR_A  = 3'd0;
  localparam logic [2:0] TCNT_A  = 3'd1;
  localparam logic [2:0] OCR_A   = 3'd2;
  localparam logic [2:0] TIMSK_A = 3'd3;
  localparam logic [2:0] TIFR_A  = 3'd4;

  localparam logic [2:0] CS_STOP    = 3'd0;
  localparam logic [2:0] CS_DIV1    = 3'd1;
  localparam logic [2:0] CS_DIV8    = 3'd2;
  localparam logic [2:0] CS_DIV64   = 3'd3;
  localparam logic [2:0] CS_DIV256  = 3'd4;
  localparam logic [2:0] CS_DIV1024 = 3'd5;

  localparam int TOV_B  = 0;
  localparam int OCF_B  = 1;
  localparam int TOIE_B = 0;
  localparam int OCIE_B = 1;
  localparam int CTC_B  = 3;
  localparam int PSR_B  = 7;

endpackage

// File: rtl/timer_tick_select.sv
// Clock-select decode: picks which prescaler pulse advances the counter.
// Reserved codes behave like a stopped timer.
module timer_tick_select
  import timer_pkg::*;
(
  input  logic [2:0] cs,
  input  logic       tick8,
  input  logic       tick64,
  input  logic       tick256,
  input  logic       tick1024,
  output logic       tick_en
);

  // Map the clock-select code onto one tick source
  always_comb begin
    tick_en = 1'b0;
    case (cs)
      CS_STOP:    tick_en = 1'b0;
      CS_DIV1:    tick_en = 1'b1;
      CS_DIV8:    tick_en = tick8;
      CS_DIV64:   tick_en = tick64;
      CS_DIV256:  tick_en = tick256;
      CS_DIV1024: tick_en = tick1024;
      default:    tick_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/timer_ctrl.sv
// AVR-style 8-bit Timer0: CPU register file, counter with compare/overflow
// flags, registered interrupt and a prescaler-reset strobe.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick8,
  input  logic              tick64,
  input  logic              tick256,
  input  logic              tick1024,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [7:0]        bus_wdata,
  input  logic              bus_we,
  input  logic              bus_re,
  output logic [7:0]        bus_rdata,
  output logic              presc_reset,
  output logic              irq
);

  logic [2:0]       cs_r;
  logic             ctc_r;
  logic [CNT_W-1:0] tcnt_r;
  logic [CNT_W-1:0] ocr_r;
  logic             toie_r;
  logic             ocie_r;
  logic             tov_r;
  logic             ocf_r;
  logic [7:0]       rdata_r;
  logic             presc_r;
  logic             irq_r;

  logic             tick_en_s;
  logic             wr_tccr_s;
  logic             wr_tcnt_s;
  logic             wr_ocr_s;
  logic             wr_timsk_s;
  logic             wr_tifr_s;
  logic [CNT_W-1:0] tcnt_nxt_s;
  logic             tov_set_s;
  logic             ocf_set_s;
  logic             tov_nxt_s;
  logic             ocf_nxt_s;
  logic [7:0]       rdata_nxt_s;

  timer_tick_select u_tick_select (
    .cs       (cs_r),
    .tick8    (tick8),
    .tick64   (tick64),
    .tick256  (tick256),
    .tick1024 (tick1024),
    .tick_en  (tick_en_s)
  );

  assign wr_tccr_s  = bus_we && (bus_addr == ADDR_W'(TCCR_A));
  assign wr_tcnt_s  = bus_we && (bus_addr == ADDR_W'(TCNT_A));
  assign wr_ocr_s   = bus_we && (bus_addr == ADDR_W'(OCR_A));
  assign wr_timsk_s = bus_we && (bus_addr == ADDR_W'(TIMSK_A));
  assign wr_tifr_s  = bus_we && (bus_addr == ADDR_W'(TIFR_A));

  // Counter next state; a CPU write to TCNT suppresses counting and flag evaluation
  always_comb begin
    tcnt_nxt_s = tcnt_r;
    tov_set_s  = 1'b0;
    ocf_set_s  = 1'b0;
    if (wr_tcnt_s) begin
      tcnt_nxt_s = bus_wdata[CNT_W-1:0];
    end else if (tick_en_s) begin
      if (ctc_r && (tcnt_r == ocr_r)) begin
        tcnt_nxt_s = '0;
        ocf_set_s  = 1'b1;
      end else begin
        tcnt_nxt_s = tcnt_r + 1'b1;
        ocf_set_s  = (tcnt_r == ocr_r);
        tov_set_s  = (tcnt_r == {CNT_W{1'b1}});
      end
    end else begin
      tcnt_nxt_s = tcnt_r;
    end
  end

  // Flags are write-1-to-clear, with a same-cycle hardware set taking priority
  always_comb begin
    tov_nxt_s = tov_set_s | (tov_r & ~(wr_tifr_s & bus_wdata[TOV_B]));
    ocf_nxt_s = ocf_set_s | (ocf_r & ~(wr_tifr_s & bus_wdata[OCF_B]));
  end

  // Read mux over the current (pre-update) register values
  always_comb begin
    rdata_nxt_s = 8'h00;
    case (bus_addr)
      ADDR_W'(TCCR_A):  rdata_nxt_s = {4'b0000, ctc_r, cs_r};
      ADDR_W'(TCNT_A):  rdata_nxt_s = 8'(tcnt_r);
      ADDR_W'(OCR_A):   rdata_nxt_s = 8'(ocr_r);
      ADDR_W'(TIMSK_A): rdata_nxt_s = {6'b000000, ocie_r, toie_r};
      ADDR_W'(TIFR_A):  rdata_nxt_s = {6'b000000, ocf_r, tov_r};
      default:          rdata_nxt_s = 8'h00;
    endcase
  end

  // Register file, counter, flags and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      cs_r    <= 3'd0;
      ctc_r   <= 1'b0;
      tcnt_r  <= '0;
      ocr_r   <= '0;
      toie_r  <= 1'b0;
      ocie_r  <= 1'b0;
      tov_r   <= 1'b0;
      ocf_r   <= 1'b0;
      rdata_r <= 8'h00;
      presc_r <= 1'b0;
      irq_r   <= 1'b0;
    end else begin
      if (wr_tccr_s) begin
        cs_r  <= bus_wdata[2:0];
        ctc_r <= bus_wdata[CTC_B];
      end
      if (wr_ocr_s) begin
        ocr_r <= bus_wdata[CNT_W-1:0];
      end
      if (wr_timsk_s) begin
        toie_r <= bus_wdata[TOIE_B];
        ocie_r <= bus_wdata[OCIE_B];
      end
      tcnt_r  <= tcnt_nxt_s;
      tov_r   <= tov_nxt_s;
      ocf_r   <= ocf_nxt_s;
      presc_r <= wr_tccr_s & bus_wdata[PSR_B];
      // Interrupt follows the flag/mask registers by one cycle
      irq_r   <= (tov_r & toie_r) | (ocf_r & ocie_r);
      if (bus_re) begin
        rdata_r <= rdata_nxt_s;
      end
    end
  end

  assign bus_rdata   = rdata_r;
  assign presc_reset = presc_r;
  assign irq         = irq_r;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: reads push expected data, a monitor pops
// and compares when read data becomes valid; irq/presc_reset checked directly.
module tb_timer_ctrl;
  import timer_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] ticks;
  logic [2:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic       presc_reset;
  logic       irq;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } rd_t;

  rd_t exp_q[$];
  rd_t cur;
  int  n_cmp = 0;
  int  n_err = 0;
  logic re_q = 1'b0;

  timer_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .tick8       (ticks[0]),
    .tick64      (ticks[1]),
    .tick256     (ticks[2]),
    .tick1024    (ticks[3]),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_we      (bus_we),
    .bus_re      (bus_re),
    .bus_rdata   (bus_rdata),
    .presc_reset (presc_reset),
    .irq         (irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] e);
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, e);
    end
  endtask

  // Read data is valid on the cycle after the strobe
  always @(posedge clock) re_q <= bus_re;

  always @(negedge clock) begin
    if (re_q) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rdata_unexpected: got %h, want no read", bus_rdata);
      end else begin
        cur = exp_q.pop_front();
        chk($sformatf("rdata_addr%0d", cur.addr), bus_rdata, cur.data);
      end
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    step();
    bus_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e);
    exp_q.push_back(rd_t'{a, e});
    bus_addr = a; bus_re = 1'b1;
    step();
    bus_re = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  int         rd_cyc[5] = '{63, 100, 127, 150, 191};
  logic [2:0] rd_adr[5] = '{TCNT_A, TCNT_A, TCNT_A, TIFR_A, TIFR_A};
  logic [7:0] rd_exp[5] = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00};

  initial begin
    reset = 1'b1; ticks = 4'b0000; bus_addr = 3'd0; bus_wdata = 8'h00;
    bus_we = 1'b0; bus_re = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_rdata", bus_rdata, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_presc", {7'b0, presc_reset}, 8'h00);
    rd(TCNT_A, 8'h00);
    rd(TIFR_A, 8'h00);

    // Overflow with TOIE
    wr(TIMSK_A, 8'h01);
    wr(TCNT_A, 8'hFE);
    wr(TCCR_A, 8'h01);
    rd(TCNT_A, 8'hFE);
    rd(TCNT_A, 8'hFF);
    chk("ovf_irq_not_yet", {7'b0, irq}, 8'h00);
    rd(TIFR_A, 8'h01);
    chk("ovf_irq_set", {7'b0, irq}, 8'h01);
    wr(TIFR_A, 8'h01);
    chk("ovf_irq_hold", {7'b0, irq}, 8'h01);
    step();
    chk("ovf_irq_clear", {7'b0, irq}, 8'h00);
    wr(TCCR_A, 8'h00);

    // CTC with OCR=4: period 5, set-wins on coincident clear
    wr(TIFR_A, 8'h03);
    wr(TCNT_A, 8'h00);
    wr(OCR_A, 8'h04);
    wr(TIMSK_A, 8'h02);
    wr(TCCR_A, 8'h09);
    rd(TCNT_A, 8'h00);
    rd(TCNT_A, 8'h01);
    rd(TCNT_A, 8'h02);
    rd(TCNT_A, 8'h03);
    rd(TCNT_A, 8'h04);
    rd(TCNT_A, 8'h00);
    rd(TIFR_A, 8'h02);
    chk("ctc_irq", {7'b0, irq}, 8'h01);
    rd(TCNT_A, 8'h02);
    step();
    wr(TIFR_A, 8'h02);
    rd(TIFR_A, 8'h02);
    rd(TCNT_A, 8'h01);
    wr(TCCR_A, 8'h00);
    wr(TIMSK_A, 8'h00);
    chk("mask_irq_hold", {7'b0, irq}, 8'h01);
    step();
    chk("mask_irq_clear", {7'b0, irq}, 8'h00);
    wr(TIFR_A, 8'h03);

    // CS=3 driven by tick64 every 64th cycle, compare at OCR=2
    wr(TCNT_A, 8'h00);
    wr(OCR_A, 8'h02);
    wr(TCCR_A, 8'h03);
    for (int i = 0; i < 192; i++) begin
      ticks[1] = (i % 64 == 63);
      bus_re = 1'b0;
      for (int j = 0; j < 5; j++) begin
        if (rd_cyc[j] == i) begin
          exp_q.push_back(rd_t'{rd_adr[j], rd_exp[j]});
          bus_addr = rd_adr[j];
          bus_re = 1'b1;
        end
      end
      step();
    end
    ticks[1] = 1'b0;
    bus_re = 1'b0;
    rd(TIFR_A, 8'h02);
    rd(TCNT_A, 8'h03);
    wr(TIFR_A, 8'h03);

    // Each CS code must respond to exactly its own tick input
    for (int cs = 2; cs < 8; cs++) begin
      wr(TCCR_A, 8'(cs));
      wr(TCNT_A, 8'h00);
      for (int k = 0; k < 4; k++) begin
        ticks[k] = 1'b1;
        step();
        ticks[k] = 1'b0;
      end
      rd(TCNT_A, (cs >= 2 && cs <= 5) ? 8'h01 : 8'h00);
    end

    // TCNT write beats a tick; read-during-write returns old value
    wr(TCCR_A, 8'h01);
    wr(TCNT_A, 8'h10);
    rd(TCNT_A, 8'h10);
    exp_q.push_back(rd_t'{TCNT_A, 8'h11});
    bus_addr = TCNT_A; bus_wdata = 8'h55; bus_we = 1'b1; bus_re = 1'b1;
    step();
    bus_we = 1'b0; bus_re = 1'b0;
    rd(TCNT_A, 8'h55);
    wr(TCCR_A, 8'h00);

    // Prescaler reset strobe, masked read-back, unmapped address
    chk("presc_idle", {7'b0, presc_reset}, 8'h00);
    wr(TCCR_A, 8'h83);
    chk("presc_pulse", {7'b0, presc_reset}, 8'h01);
    step();
    chk("presc_end", {7'b0, presc_reset}, 8'h00);
    rd(TCCR_A, 8'h03);
    wr(3'd5, 8'hFF);
    rd(3'd5, 8'h00);
    wr(TIMSK_A, 8'hFF);
    rd(TIMSK_A, 8'h03);
    rd(OCR_A, 8'h02);

    // Reset in the middle of a running count
    wr(TIFR_A, 8'h03);
    wr(TCCR_A, 8'h01);
    wr(TCNT_A, 8'hFE);
    repeat (4) step();
    chk("pre_reset_irq", {7'b0, irq}, 8'h01);
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    chk("mid_rst_irq", {7'b0, irq}, 8'h00);
    chk("mid_rst_rdata", bus_rdata, 8'h00);
    rd(TCNT_A, 8'h00);
    rd(TIFR_A, 8'h00);
    rd(TCCR_A, 8'h00);
    rd(TIMSK_A, 8'h00);
    rd(OCR_A, 8'h00);

    repeat (2) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending reads, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
